// File: rtl/keypad_scan_encoder_if.sv
// keypad_scan_encoder_if: raw key lines and enable in, encoded key event outputs back.
interface keypad_scan_encoder_if #(
    parameter int NUM_KEYS = 10,
    parameter int CODE_W   = 4
);
    logic [NUM_KEYS-1:0] keypad;
    logic                enablen;
    logic [CODE_W-1:0]   code;
    logic                data_valid;
    logic                key_strobe;
    logic                multi_key;

    modport master (output keypad, enablen, input code, data_valid, key_strobe, multi_key);
    modport slave  (input keypad, enablen, output code, data_valid, key_strobe, multi_key);
endinterface

// File: rtl/keypad_scan_encoder.sv
// keypad_scan_encoder: synchronise, debounce and priority-encode keypad lines into key events.
// Define KEYPAD_AUTOREPEAT_EN to re-strobe a held key every REPEAT_CYCLES clocks.
module keypad_scan_encoder #(
    parameter int NUM_KEYS        = 10,
    parameter int CODE_W          = 4,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_CYCLES   = 16
) (
    input logic                  clk,
    input logic                  reset,
    keypad_scan_encoder_if.slave bus
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    if (NUM_KEYS < 2 || NUM_KEYS > 16) begin : g_bad_keys
        $error("NUM_KEYS out of range");
    end
    if ((1 << CODE_W) < NUM_KEYS) begin : g_bad_code
        $error("CODE_W too narrow for NUM_KEYS");
    end
    if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 255) begin : g_bad_deb
        $error("DEBOUNCE_CYCLES out of range");
    end
    if (REPEAT_CYCLES < 2 || REPEAT_CYCLES > 65535) begin : g_bad_rep
        $error("REPEAT_CYCLES out of range");
    end

    typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED, RELEASE} state_t;

    state_t              state, state_n;
    logic [NUM_KEYS-1:0] s1, s;
    logic [CW-1:0]       cnt, cnt_n;
    logic [CODE_W-1:0]   cand, cand_n, code_n, enc;
    logic                valid_n, strobe_n, hit, last;

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int RW = $clog2(REPEAT_CYCLES);
    logic [RW-1:0] rep, rep_n;
    logic          rep_wrap;
    assign rep_wrap = rep == RW'(REPEAT_CYCLES - 1);
`endif

    assign hit  = |s;
    assign last = cnt == CW'(DEBOUNCE_CYCLES - 1);

    // Ascending scan so the highest set line wins.
    always_comb begin
        enc = '0;
        for (int i = 0; i < NUM_KEYS; i++)
            if (s[i]) enc = CODE_W'(i);
    end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        cand_n   = cand;
        code_n   = bus.code;
        valid_n  = bus.data_valid;
        strobe_n = 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
        rep_n    = rep;
`endif
        if (bus.enablen) begin
            state_n = IDLE;
            valid_n = 1'b0;
        end else begin
            case (state)
                IDLE: if (hit) begin
                    state_n = DEBOUNCE;
                    cand_n  = enc;
                    cnt_n   = CW'(1);
                end
                DEBOUNCE: if (hit && enc == cand) begin
                    cnt_n = cnt + CW'(1);
                    if (last) begin
                        state_n  = PRESSED;
                        code_n   = cand;
                        valid_n  = 1'b1;
                        strobe_n = 1'b1;
`ifdef KEYPAD_AUTOREPEAT_EN
                        rep_n    = '0;
`endif
                    end
                end else begin
                    state_n = IDLE;
                end
                PRESSED: if (!hit) begin
                    state_n = RELEASE;
                    cnt_n   = CW'(1);
                end
`ifdef KEYPAD_AUTOREPEAT_EN
                else begin
                    rep_n    = rep_wrap ? '0 : rep + RW'(1);
                    strobe_n = rep_wrap;
                end
`endif
                RELEASE: if (hit) begin
                    state_n = PRESSED;
                end else if (last) begin
                    state_n = IDLE;
                    valid_n = 1'b0;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1             <= '0;
            s              <= '0;
            state          <= IDLE;
            cnt            <= '0;
            cand           <= '0;
            bus.code       <= '0;
            bus.data_valid <= 1'b0;
            bus.key_strobe <= 1'b0;
            bus.multi_key  <= 1'b0;
        end else begin
            s1             <= bus.keypad;
            s              <= s1;
            state          <= state_n;
            cnt            <= cnt_n;
            cand           <= cand_n;
            bus.code       <= code_n;
            bus.data_valid <= valid_n;
            bus.key_strobe <= strobe_n;
            bus.multi_key  <= |(s & (s - NUM_KEYS'(1)));
        end
    end

`ifdef KEYPAD_AUTOREPEAT_EN
    always_ff @(posedge clk) begin
        if (reset) rep <= '0;
        else rep <= rep_n;
    end
`endif
endmodule

// File: tb/tb_keypad_scan_encoder.sv
// tb_keypad_scan_encoder: table, directed and random checks against a behavioural key model.
module tb_keypad_scan_encoder;
    localparam int NK = 10, CW = 4, DC = 4, RP = 16;
`ifdef KEYPAD_AUTOREPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    keypad_scan_encoder_if #(.NUM_KEYS(NK), .CODE_W(CW)) bus ();
    keypad_scan_encoder #(.NUM_KEYS(NK), .CODE_W(CW), .DEBOUNCE_CYCLES(DC), .REPEAT_CYCLES(RP))
        dut (.clk(clk), .reset(reset), .bus(bus));

    int nvec = 0, nbad = 0;
    int m_s1 = 0, m_s2 = 0, run = 0, cand = 0, m_code = 0, rep = 0;
    bit held = 0, m_strobe = 0, m_multi = 0;

    typedef struct {
        logic [NK-1:0] kp;
        logic          en_n;
        int            hold;
        int            code;
        bit            valid;
        bit            multi;
    } vec_t;
    vec_t tbl[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: held = a key is accepted; run counts matching samples toward a press or release.
    task automatic model_step();
        int smp, e;
        smp = m_s2;
        e = $clog2(smp + 1) - 1;
        if (reset) begin
            m_s1 = 0; m_s2 = 0; held = 0; run = 0; cand = 0;
            m_code = 0; m_strobe = 0; m_multi = 0; rep = 0;
            return;
        end
        m_strobe = 0;
        m_multi = $countones(smp) > 1;
        if (bus.enablen) begin
            held = 0; run = 0;
        end else if (!held) begin
            if (run == 0) begin
                if (smp != 0) begin cand = e; run = 1; end
            end else if (smp != 0 && e == cand) begin
                run++;
                if (run == DC) begin held = 1; run = 0; m_code = cand; m_strobe = 1; rep = 0; end
            end else run = 0;
        end else begin
            if (run == 0) begin
                if (smp == 0) run = 1;
                else if (AR) begin
                    rep++;
                    if (rep == RP) begin rep = 0; m_strobe = 1; end
                end
            end else if (smp == 0) begin
                run++;
                if (run == DC) begin held = 0; run = 0; end
            end else run = 0;
        end
        m_s2 = m_s1;
        m_s1 = int'(bus.keypad);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        chk("model_code", bus.code, m_code);
        chk("model_valid", bus.data_valid, held);
        chk("model_strobe", bus.key_strobe, m_strobe);
        chk("model_multi", bus.multi_key, m_multi);
    endtask

    int pick;
    bit found;

    initial begin
        bus.keypad = '0;
        bus.enablen = 1'b0;
        tbl[0] = '{10'h000, 1'b0, 6, 0, 0, 0};
        tbl[1] = '{10'h008, 1'b0, 10, 3, 1, 0};
        tbl[2] = '{10'h000, 1'b0, 10, 3, 0, 0};
        tbl[3] = '{10'h210, 1'b0, 10, 9, 1, 1};
        tbl[4] = '{10'h000, 1'b0, 10, 9, 0, 0};
        tbl[5] = '{10'h020, 1'b1, 10, 9, 0, 0};
        tbl[6] = '{10'h020, 1'b0, 10, 5, 1, 0};
        tbl[7] = '{10'h0a0, 1'b0, 10, 5, 1, 1};
        tbl[8] = '{10'h000, 1'b0, 10, 5, 0, 0};

        repeat (2) tick();
        chk("reset_code", bus.code, 0);
        chk("reset_valid", bus.data_valid, 0);
        chk("reset_strobe", bus.key_strobe, 0);
        chk("reset_multi", bus.multi_key, 0);
        reset = 1'b0;

        for (int i = 0; i < 9; i++) begin
            bus.keypad = tbl[i].kp;
            bus.enablen = tbl[i].en_n;
            repeat (tbl[i].hold) tick();
            chk($sformatf("tbl%0d_code", i), bus.code, tbl[i].code);
            chk($sformatf("tbl%0d_valid", i), bus.data_valid, tbl[i].valid);
            chk($sformatf("tbl%0d_multi", i), bus.multi_key, tbl[i].multi);
        end

        bus.keypad = 10'h008;
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk("press_latency", bus.key_strobe, k == 6);
        end
        chk("press_code", bus.code, 3);
        chk("press_valid", bus.data_valid, 1);
        bus.keypad = '0;
        repeat (10) tick();

        for (int k = 0; k < 24; k++) begin
            bus.keypad = ((k / 2) % 2) ? 10'h004 : 10'h000;
            tick();
            chk("toggle_strobe", bus.key_strobe, 0);
            chk("toggle_valid", bus.data_valid, 0);
        end
        bus.keypad = '0;
        repeat (4) tick();

        bus.keypad = 10'h020;
        repeat (10) tick();
        chk("hold5_valid", bus.data_valid, 1);
        bus.keypad = '0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk("release_valid", bus.data_valid, k < 6);
        end
        bus.keypad = 10'h020;
        repeat (10) tick();
        bus.keypad = '0;
        repeat (3) tick();
        bus.keypad = 10'h020;
        tick();
        bus.keypad = '0;
        for (int k = 0; k < 15; k++) begin
            tick();
            chk("bounce_strobe", bus.key_strobe, 0);
        end
        chk("bounce_valid", bus.data_valid, 0);

        bus.keypad = 10'h008;
        repeat (10) tick();
        bus.enablen = 1'b1;
        tick();
        chk("disable_valid", bus.data_valid, 0);
        chk("disable_strobe", bus.key_strobe, 0);
        chk("disable_code", bus.code, 3);
        bus.enablen = 1'b0;
        bus.keypad = '0;
        repeat (10) tick();

        bus.keypad = 10'h004;
        repeat (4) tick();
        reset = 1'b1;
        bus.keypad = '0;
        tick();
        chk("rst_mid_code", bus.code, 0);
        chk("rst_mid_valid", bus.data_valid, 0);
        chk("rst_mid_strobe", bus.key_strobe, 0);
        chk("rst_mid_multi", bus.multi_key, 0);
        reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("rst_mid_nostrobe", bus.key_strobe, 0);
        end

`ifdef KEYPAD_AUTOREPEAT_EN
        bus.keypad = 10'h080;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            tick();
            found = bus.key_strobe;
        end
        chk("repeat_accept", found, 1);
        for (int k = 1; k <= 60; k++) begin
            tick();
            chk("repeat_strobe", bus.key_strobe, (k % 16) == 0);
        end
        chk("repeat_code", bus.code, 7);
        bus.keypad = '0;
        repeat (10) tick();
`endif

        for (int n = 0; n < 400; n++) begin
            pick = $urandom_range(0, 9);
            bus.keypad = pick < 3 ? NK'(0) : pick < 8 ? NK'(1) << $urandom_range(0, NK - 1) : NK'($urandom);
            bus.enablen = $urandom_range(0, 15) == 0;
            reset = $urandom_range(0, 60) == 0;
            repeat ($urandom_range(1, 12)) tick();
        end
        reset = 1'b0;
        bus.enablen = 1'b0;
        bus.keypad = '0;
        repeat (10) tick();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end
endmodule
